// File: rtl/platform_scroller_if.sv
// Bus between the platform scroller, the frame controller that kicks it, and
// the renderer that consumes its platform table.
interface platform_scroller_if #(
  parameter int N_ROWS = 31
);
  localparam int N_SLOTS = 3 * N_ROWS;

  logic                                 frame_start;
  logic [4:0]                           scroll_delta;
  logic [15:0]                          random_sides;
  logic signed [N_SLOTS-1:0][1:0][10:0] platforms;
  logic [N_SLOTS-1:0]                   platform_activation;
  logic                                 busy;
  logic                                 done;
  logic [15:0]                          rows_recycled;

  modport master (
    output frame_start, scroll_delta, random_sides,
    input  platforms, platform_activation, busy, done, rows_recycled
  );

  modport slave (
    input  frame_start, scroll_delta, random_sides,
    output platforms, platform_activation, busy, done, rows_recycled
  );
endinterface

// File: rtl/platform_scroller.sv
// Per-frame platform table update: walks the rows one per clock, scrolls them
// down and recycles rows leaving the bottom to the top with new activation.
module platform_scroller #(
  parameter int N_ROWS    = 31,
  parameter int ROW_PITCH = 30,
  parameter int TOP_Y     = -162,
  parameter int X0        = 342,
  parameter int X_PITCH   = 114,
  parameter int BOTTOM_Y  = 768,
  parameter logic [3*N_ROWS-1:0] RESET_ACTIVE = (3*N_ROWS)'(1) << 40
) (
  input  logic               clk,
  input  logic               rst,
  platform_scroller_if.slave bus
);
  localparam int N_SLOTS = 3 * N_ROWS;
  localparam int PTR_W   = $clog2(N_ROWS);
  localparam int SLOT_W  = $clog2(N_SLOTS);

  localparam logic [PTR_W-1:0]   LAST_ROW  = PTR_W'(N_ROWS - 1);
  localparam logic [4:0]         MAX_DELTA = 5'(ROW_PITCH - 1);
  localparam logic signed [10:0] BOTTOM    = 11'(BOTTOM_Y);
  localparam logic signed [10:0] WRAP      = 11'(N_ROWS * ROW_PITCH);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t                         state_reg, state_next;
  logic [PTR_W-1:0]               ptr_reg;
  logic [4:0]                     delta_reg;
  logic [1:0]                     empty_run_reg, empty_run_next;
  logic [15:0]                    rows_recycled_reg;
  logic [N_SLOTS-1:0]             activation_reg;
  logic signed [10:0]             y_reg [N_ROWS];

  logic signed [10:0]             y_cur, y_sum, y_new;
  logic                           recycle;
  logic [2:0]                     fresh_bits;
  logic [SLOT_W-1:0]              slot_base;
  logic [4:0]                     delta_sat;
  logic signed [N_SLOTS-1:0][1:0][10:0] slot_table;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.frame_start) state_next = SCAN;
      SCAN:    if (ptr_reg == LAST_ROW) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    delta_sat      = (bus.scroll_delta > MAX_DELTA) ? MAX_DELTA : bus.scroll_delta;
    y_cur          = y_reg[ptr_reg];
    y_sum          = y_cur + $signed({6'b0, delta_reg});
    recycle        = (y_sum >= BOTTOM);
    y_new          = recycle ? (y_sum - WRAP) : y_sum;
    slot_base      = SLOT_W'(ptr_reg) * SLOT_W'(3);
    fresh_bits     = 3'b000;
    empty_run_next = empty_run_reg;
    // Three empty rows in a row would leave an unjumpable gap, so the third is forced to the middle.
    if (bus.random_sides[1:0] != 2'd3) begin
      fresh_bits     = 3'b001 << bus.random_sides[1:0];
      empty_run_next = 2'd0;
    end else if (empty_run_reg < 2'd2) begin
      empty_run_next = empty_run_reg + 2'd1;
    end else begin
      fresh_bits     = 3'b010;
      empty_run_next = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      ptr_reg           <= '0;
      delta_reg         <= '0;
      empty_run_reg     <= '0;
      rows_recycled_reg <= '0;
      activation_reg    <= RESET_ACTIVE;
      for (int r = 0; r < N_ROWS; r++) begin
        y_reg[r] <= 11'(TOP_Y + r * ROW_PITCH);
      end
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.frame_start) begin
            delta_reg <= delta_sat;
            ptr_reg   <= '0;
          end
        end
        SCAN: begin
          y_reg[ptr_reg] <= y_new;
          if (ptr_reg != LAST_ROW) ptr_reg <= ptr_reg + 1'b1;
          if (recycle) begin
            activation_reg[slot_base +: 3] <= fresh_bits;
            empty_run_reg                  <= empty_run_next;
            rows_recycled_reg              <= rows_recycled_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // All three slots of a row share the row's y; x is a fixed column position.
  genvar gi, gc;
  generate
    for (gi = 0; gi < N_ROWS; gi++) begin : g_row
      for (gc = 0; gc < 3; gc++) begin : g_col
        assign slot_table[gi*3+gc][0] = y_reg[gi];
        assign slot_table[gi*3+gc][1] = 11'(X0 + gc * X_PITCH);
      end
    end
  endgenerate

  assign bus.platforms           = slot_table;
  assign bus.platform_activation = activation_reg;
  assign bus.busy                = (state_reg == SCAN);
  assign bus.done                = (state_reg == FIN);
  assign bus.rows_recycled       = rows_recycled_reg;
endmodule

// File: tb/tb_platform_scroller.sv
// Directed bench for platform_scroller: reset state, pass timing, recycling,
// empty-run cap, delta saturation, ignored pulses and reset priority.
module tb_platform_scroller;
  localparam logic [92:0] RESET_ACTIVE = 93'(1) << 40;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // reference model of the table
  longint     y_m [31];
  logic [92:0] act_m;
  int         run_m;
  longint     rec_m;

  platform_scroller_if #(.N_ROWS(31)) bif ();

  platform_scroller dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [92:0] obs, input logic [92:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint y_of(input int i);
    return longint'($signed(bif.platforms[i][0]));
  endfunction

  function automatic longint x_of(input int i);
    return longint'($signed(bif.platforms[i][1]));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 31; r++) y_m[r] = -162 + r * 30;
    act_m = RESET_ACTIVE;
    run_m = 0;
    rec_m = 0;
  endtask

  task automatic model_pass(input int d_in, input int s);
    int d;
    logic [2:0] bits;
    d = (d_in > 29) ? 29 : d_in;
    for (int r = 0; r < 31; r++) begin
      y_m[r] = y_m[r] + d;
      if (y_m[r] >= 768) begin
        y_m[r] = y_m[r] - 930;
        rec_m = (rec_m + 1) % 65536;
        if (s < 3) begin
          bits = 3'b001 << s;
          run_m = 0;
        end else if (run_m < 2) begin
          bits = 3'b000;
          run_m++;
        end else begin
          bits = 3'b010;
          run_m = 0;
        end
        act_m[r*3 +: 3] = bits;
      end
    end
  endtask

  task automatic check_table(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 93; i++) begin
      if (y_of(i) != y_m[i/3]) mism++;
      if (x_of(i) != 342 + (i % 3) * 114) mism++;
    end
    check({tag, " table mismatches"}, mism, 0);
    check_vec({tag, " activation"}, bif.platform_activation, act_m);
    check({tag, " rows_recycled"}, longint'(bif.rows_recycled), rec_m);
  endtask

  // Launch a pass in the current cycle T and follow it to T+33.
  task automatic run_pass(input int d_in, input int s, input int pulse_at, input string tag);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    bif.scroll_delta = 5'(d_in);
    bif.random_sides = (16'($urandom) & 16'hFFFC) | 16'(s);
    bif.frame_start  = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      bif.frame_start = (k == pulse_at);
      if (bif.busy) busy_cnt++;
      if (bif.done) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 1)  check({tag, " busy at T+1"}, longint'(bif.busy), 1);
      if (k == 31) check({tag, " busy at T+31"}, longint'(bif.busy), 1);
      if (k == 32) check({tag, " busy at T+32"}, longint'(bif.busy), 0);
    end
    check({tag, " busy cycles"}, busy_cnt, 31);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " done cycle"}, done_at, 32);
    @(negedge clk);
    check({tag, " done at T+33"}, longint'(bif.done), 0);
    check({tag, " busy at T+33"}, longint'(bif.busy), 0);
    model_pass(d_in, s);
    check_table(tag);
    $display("pass %s delta=%0d sides=%0d rows_recycled=%0d", tag, d_in, s, bif.rows_recycled);
  endtask

  initial begin
    int done_seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bif.frame_start  = 1'b0;
    bif.scroll_delta = '0;
    bif.random_sides = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();

    check("reset y0", y_of(0), -162);
    check("reset y92", y_of(92), 738);
    check("reset x5", x_of(5), 570);
    check_vec("reset activation", bif.platform_activation, RESET_ACTIVE);
    check("reset busy", longint'(bif.busy), 0);
    check("reset done", longint'(bif.done), 0);
    check("reset rows_recycled", longint'(bif.rows_recycled), 0);
    $display("reset checked");

    run_pass(29, 0, 0, "no_recycle");
    check("p1 row0 y", y_of(0), -133);
    check("p1 row30 y", y_of(90), 767);

    run_pass(29, 2, 0, "recycle");
    check("p2 row30 y", y_of(91), -134);
    check("p2 row29 y", y_of(87), 766);
    check("p2 act 92:90", longint'(bif.platform_activation[92:90]), 3'b100);
    check("p2 rows_recycled", longint'(bif.rows_recycled), 1);

    run_pass(29, 3, 0, "empty1");
    run_pass(29, 3, 0, "empty2");
    run_pass(29, 3, 0, "empty3");
    check("cap row29 bits", longint'(bif.platform_activation[89:87]), 3'b000);
    check("cap row28 bits", longint'(bif.platform_activation[86:84]), 3'b000);
    check("cap row27 bits", longint'(bif.platform_activation[83:81]), 3'b010);
    check("cap row27 y", y_of(81), -137);
    check("cap empty_run", longint'(dut.empty_run_reg), 0);
    check("cap rows_recycled", longint'(bif.rows_recycled), 4);

    run_pass(31, 0, 10, "saturate");
    check("sat row0 y", y_of(0), 12);
    check("sat row26 y", y_of(78), -138);
    check("sat row26 bits", longint'(bif.platform_activation[80:78]), 3'b001);
    @(negedge clk);
    check("sat no queued pass", longint'(bif.busy), 0);

    // rst and frame_start together: reset wins and the request is dropped
    rst = 1'b1;
    bif.frame_start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bif.frame_start = 1'b0;
    check("rst prio busy", longint'(bif.busy), 0);
    @(negedge clk);
    check("rst prio busy next", longint'(bif.busy), 0);
    check("rst prio y30", y_of(90), 738);
    model_reset();
    $display("reset priority checked");

    run_pass(0, 1, 0, "delta0");
    check("d0 row0 y", y_of(0), -162);

    // mid-pass reset
    bif.scroll_delta = 5'd10;
    bif.random_sides = 16'h0000;
    bif.frame_start  = 1'b1;
    done_seen = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bif.frame_start = 1'b0;
      if (bif.done) done_seen++;
      if (k == 15) begin
        check("mid row13 scrolled", y_of(39), 238);
        check("mid row14 pending", y_of(42), 258);
        rst = 1'b1;
      end
    end
    rst = 1'b0;
    check("mid reset y0", y_of(0), -162);
    check("mid reset y92", y_of(92), 738);
    check("mid reset busy", longint'(bif.busy), 0);
    check("mid reset done", longint'(bif.done), 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bif.done) done_seen++;
    end
    check("mid reset no done", done_seen, 0);
    model_reset();
    check_table("mid_reset");
    $display("mid-pass reset checked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
